// File: rtl/fetchbuffer_if.sv
`default_nettype none
// ============================================================================
// Interface : fetchbuffer_if
// Purpose   : Memory-style request/response bus shared by the fetch-stage side
//             and the instruction-memory side of the prefetch buffer.
// Revision  : 1.0
// ============================================================================
interface fetchbuffer_if;
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_spec;
    logic        mem_fence;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_instr, mem_spec, mem_fence, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    // The buffer never writes memory, so the write fields are left off its view.
    modport slave (
        input  mem_valid, mem_spec, mem_fence, mem_addr,
        output mem_ready, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/fetchbuffer.sv
`default_nettype none
// ============================================================================
// Module   : fetchbuffer
// Purpose  : Halfword prefetch queue between instruction memory and the fetch
//            stage, with zero-cycle lookup of 32-bit or compressed instructions.
// Revision : 1.0
// ============================================================================
module fetchbuffer #(
    parameter int DEPTH = 8
) (
    input  wire logic     clock,
    input  wire logic     reset,
    fetchbuffer_if.slave  fetch_bus,
    fetchbuffer_if.master imem_bus
);
    localparam int          PW       = $clog2(DEPTH);
    localparam logic [PW:0] CAPACITY = (PW + 1)'(DEPTH);
    localparam logic [PW:0] ONE      = (PW + 1)'(1);
    localparam logic [PW:0] TWO      = (PW + 1)'(2);
    localparam logic [PW-1:0] IDX_ONE = PW'(1);

    logic [15:0] queue [DEPTH];
    logic [PW:0] rd_ptr;
    logic [PW:0] wr_ptr;
    logic [31:0] head_addr;
    logic [31:0] fetch_addr;
    logic [31:0] req_addr;
    logic        busy;
    logic        kill;
    logic        started;

    logic [31:0] addr;
    logic [PW:0] count;
    logic [PW:0] pop_n;
    logic [PW:0] post_rd;
    logic [PW:0] post_count;
    logic [PW:0] free_after;
    logic [PW-1:0] h1_idx;
    logic [PW-1:0] wr_idx1;
    logic [15:0] h0;
    logic [15:0] h1;
    logic        hit0;
    logic        hit2;
    logic        hit4;
    logic        flush;
    logic        ready;
    logic        resp;
    logic        accept;
    logic        upper_only;
    logic        issue;
    logic [31:0] post_head;
    logic [31:0] issue_addr;

    always_comb begin
        addr  = fetch_bus.mem_addr;
        count = wr_ptr - rd_ptr;
        hit0  = (addr == head_addr);
        hit2  = (addr == head_addr + 32'd2) && (count >= ONE);
        hit4  = (addr == head_addr + 32'd4) && (count >= TWO);
        flush = fetch_bus.mem_valid &&
                (fetch_bus.mem_spec || fetch_bus.mem_fence || !started || !(hit0 || hit2 || hit4));

        pop_n = '0;
        if (fetch_bus.mem_valid && !flush) begin
            pop_n = hit2 ? ONE : (hit4 ? TWO : '0);
        end
        post_rd    = rd_ptr + pop_n;
        post_count = count - pop_n;
        free_after = CAPACITY - post_count;

        h1_idx = post_rd[PW-1:0] + IDX_ONE;
        h0     = queue[post_rd[PW-1:0]];
        h1     = queue[h1_idx];

        // A 32-bit instruction needs both halves resident before it is offered.
        ready = fetch_bus.mem_valid && !flush && (post_count != '0) &&
                ((h0[1:0] != 2'b11) || (post_count >= TWO));

        resp       = busy && imem_bus.mem_ready;
        accept     = resp && !kill && !flush;
        post_head  = fetch_bus.mem_valid ? addr : head_addr;
        upper_only = (post_count == '0) && post_head[1];
        wr_idx1    = wr_ptr[PW-1:0] + IDX_ONE;

        issue      = !busy && (flush || (started && (free_after >= TWO)));
        issue_addr = flush ? {addr[31:2], 2'b00} : fetch_addr;
    end

    assign fetch_bus.mem_ready = ready;
    assign fetch_bus.mem_rdata = !ready ? 32'h0 :
                                 (h0[1:0] == 2'b11) ? {h1, h0} : {16'h0, h0};

    assign imem_bus.mem_valid = busy;
    assign imem_bus.mem_addr  = req_addr;
    assign imem_bus.mem_instr = 1'b1;
    assign imem_bus.mem_spec  = 1'b0;
    assign imem_bus.mem_fence = 1'b0;
    assign imem_bus.mem_wdata = 32'h0;
    assign imem_bus.mem_wstrb = 4'h0;

    always_ff @(posedge clock) begin
        if (reset && accept) begin
            if (upper_only) begin
                queue[wr_ptr[PW-1:0]] <= imem_bus.mem_rdata[31:16];
            end else begin
                queue[wr_ptr[PW-1:0]] <= imem_bus.mem_rdata[15:0];
                queue[wr_idx1]        <= imem_bus.mem_rdata[31:16];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            head_addr  <= 32'h0;
            fetch_addr <= 32'h0;
            req_addr   <= 32'h0;
            busy       <= 1'b0;
            kill       <= 1'b0;
            started    <= 1'b0;
        end else begin
            if (fetch_bus.mem_valid) begin
                head_addr <= addr;
            end
            if (flush) begin
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                fetch_addr <= {addr[31:2], 2'b00};
                started    <= 1'b1;
                // A response landing in the flush cycle is simply dropped.
                kill       <= busy && !resp;
            end else begin
                rd_ptr <= post_rd;
                if (accept) begin
                    wr_ptr     <= wr_ptr + (upper_only ? ONE : TWO);
                    fetch_addr <= fetch_addr + 32'd4;
                end
                if (resp) begin
                    kill <= 1'b0;
                end
            end
            if (resp) begin
                busy <= 1'b0;
            end
            if (issue) begin
                busy     <= 1'b1;
                req_addr <= issue_addr;
            end
        end
    end
endmodule
`default_nettype wire

// File: doc/fetchbuffer.md
# fetchbuffer

- Instruction prefetch buffer between instruction memory and `fetch_stage`.
- Fetches aligned 32-bit words from instruction memory and stores them as 16-bit halfwords in a circular queue.
- Returns the 32-bit or compressed instruction at the PC that `fetch_stage` presents.
- Discards queued data on speculation redirects and fences.

## Interface
- `DEPTH`, 8, queue capacity in halfwords; power of two, at least 4.
- `reset` in 1: synchronous, active-low.
- `clock` in 1: rising-edge clock.
- `fetchbuffer_in` in mem_in_type: request from fetch stage. Uses `mem_valid`, `mem_spec`, `mem_fence`, `mem_addr`. Ignores `mem_wdata`/`mem_wstrb`.
- `fetchbuffer_out` out mem_out_type: `mem_ready`, `mem_rdata` (instruction).
- `imem_in` out mem_in_type: word request to instruction memory. `mem_instr`=1, `mem_wdata`=0, `mem_wstrb`=0, `mem_spec`=0, `mem_fence`=0.
- `imem_out` in mem_out_type: `mem_ready`, `mem_rdata` (32-bit word).

## Operation
**State**
- `rd_ptr`, `wr_ptr`: log2(DEPTH)+1 bits each, wrapping. Count = `wr_ptr - rd_ptr`. Full when count == DEPTH.
- `head_addr`: byte address of the entry at `rd_ptr`.
- `fetch_addr`: word-aligned address of the next word to request.
- `busy`: a request is outstanding.
- `kill`: the outstanding response is stale.
- `started`: a fetch target is known.

**Request decode**, evaluated every cycle while `mem_valid`=1, with `a = mem_addr`:
- Flush if `mem_spec`=1, or `mem_fence`=1, or `started`=0, or `a` is none of `head_addr`, `head_addr`+2, `head_addr`+4.
- Flush: empty the queue. Set `head_addr`=a, `fetch_addr`={a[31:2],2'b00}, `started`=1. Set `kill`=`busy`. `mem_ready`=0 this cycle.
- No flush, `a == head_addr`: no pop.
- No flush, `a == head_addr+2`: pop 1 entry; requires count ≥ 1, otherwise flush.
- No flush, `a == head_addr+4`: pop 2 entries; requires count ≥ 2, otherwise flush.
- After pops, `head_addr` = a. Lookup uses the post-pop head in the same cycle.
- While `mem_valid`=0: no pops, no flush, `mem_ready`=0.

**Output**
- `h0` = entry at the post-pop head; `h1` = the next entry.
- `mem_ready`=1 when no flush this cycle, count ≥ 1, and either:
  - `h0[1:0]` != 2'b11, or
  - count ≥ 2.
- `mem_rdata` = {`h1`,`h0`} if `h0[1:0]`==2'b11, else {16'h0,`h0`}.
- `mem_rdata` = 0 when not ready.

**Memory side**
- Issue a request when `started`=1, `busy`=0, and free entries ≥ 2 after this cycle's pops. Set `busy`=1.
- `imem_in.mem_valid` and `mem_addr`=`fetch_addr` are registered and held stable until `imem_out.mem_ready`=1.
- On response with `kill`=1: drop the data, clear `busy` and `kill`.
- On response with `kill`=0:
  - If the queue is empty and `head_addr[1]`=1: push `rdata[31:16]` only.
  - Otherwise push `rdata[15:0]` then `rdata[31:16]`.
  - `fetch_addr` += 4; clear `busy`.
- A flush in the same cycle as a response has priority: the response is dropped and `kill`=0.
- Pointer arithmetic wraps modulo 2·DEPTH; `fetch_addr` wraps modulo 2^32.

## Timing
- **Reset values:** queue empty; `started`=0, `busy`=0, `kill`=0. `imem_in.mem_valid`=0, `imem_in.mem_addr`=0. `fetchbuffer_out.mem_ready`=0, `fetchbuffer_out.mem_rdata`=0.
- **Reset mid-transaction:** abandons the outstanding request. Memory must tolerate a dropped request.
- **Lookup path:** combinational from `fetchbuffer_in` to `fetchbuffer_out`, zero-cycle. `fetch_stage` samples `mem_ready` in the same cycle.
- **Redirect at cycle t:** `imem_in.mem_valid`=1 at t+1, or after the killed response returns. With single-cycle memory (ready at t+1), data is written at the end of t+1 and `mem_ready`=1 at t+2 at the earliest.
- **Concurrency:** pop and push may occur in the same cycle; a full queue with a 2-pop may accept a response the same cycle.
- **Outstanding requests:** at most one.

## Test plan
- **Sequential 32-bit code:** after reset, requests at 0x100, 0x104, 0x108; words 0x00000013 each.
  - Ready at cycle 2 of each new word.
  - `mem_rdata`=0x00000013.
  - No flush after the first.
- **Mixed compressed:** words 0x45014501, 0x00A00513 from 0x200.
  - PCs 0x200 → rdata 0x00004501; 0x202 → 0x00004501; 0x204 → 0x00A00513.
- **Unaligned start and split instruction:** redirect to 0x302.
  - Word at 0x300 = 0x0513_xxxx, word at 0x304 = 0xxxxx_00A0.
  - Only the upper half of 0x300 is pushed.
  - Ready waits for the second word; rdata=0x00A00513.
- **Redirect with outstanding request:** `mem_spec`=1 to 0x400 while the 0x10C response is pending, memory delayed 3 cycles.
  - Stale data is dropped.
  - Next `imem_in.mem_addr`=0x400.
  - No stale instruction is ever ready.
- **Full queue:** DEPTH=8, hold PC constant.
  - Exactly 4 words are fetched, then `imem_in.mem_valid`=0.
  - After PC +4, one more request is issued.
- **Fence and reset:**
  - `mem_fence`=1 at 0x500 flushes; ready=0 that cycle, refetch from 0x500.
  - Reset asserted mid-request returns all outputs to zero the next cycle.
